reg_write_arbiter: RTL and testbench

//  Owns the 5-entry config register bank (output/PWM enables, duty cycle) and shares its single write

---
 rtl/spi_regs_pkg.sv | 20 ++
 rtl/reg_write_arbiter_if.sv | 30 +++
 rtl/spi_wr_holdbuf.sv | 36 +++
 rtl/reg_write_arbiter.sv | 119 +++++++++++
 tb/tb_reg_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI config register bank: widths, register map and
// the write-source encoding reported on wr_src.
package spi_regs_pkg;

    localparam int DEF_ADDR_W   = 7;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_EN_OUT_LO = 7'h00;
    localparam logic [DEF_ADDR_W-1:0] REG_EN_OUT_HI = 7'h01;
    localparam logic [DEF_ADDR_W-1:0] REG_EN_PWM_LO = 7'h02;
    localparam logic [DEF_ADDR_W-1:0] REG_EN_PWM_HI = 7'h03;
    localparam logic [DEF_ADDR_W-1:0] REG_PWM_DUTY  = 7'h04;

    typedef enum logic {
        SRC_SPI  = 1'b0,
        SRC_HOST = 1'b1
    } wr_src_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-request bundle for the register bank: fire-and-forget SPI pulses plus
// the valid/ready host channel and its lock.
interface reg_write_arbiter_if
    import spi_regs_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              spi_wr_valid;
    logic [ADDR_W-1:0] spi_wr_addr;
    logic [DATA_W-1:0] spi_wr_data;
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_lock;

    modport master (
        output spi_wr_valid, spi_wr_addr, spi_wr_data,
        output host_wr_valid, host_wr_addr, host_wr_data, host_lock,
        input  host_wr_ready
    );

    modport slave (
        input  spi_wr_valid, spi_wr_addr, spi_wr_data,
        input  host_wr_valid, host_wr_addr, host_wr_data, host_lock,
        output host_wr_ready
    );

endinterface

// File: rtl/spi_wr_holdbuf.sv
// One-entry holding buffer for SPI writes. A push arriving while the entry is
// occupied and not being drained is dropped and flagged on ovf.
module spi_wr_holdbuf #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              ovf
);

    assign ovf = push & pend & ~pop;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (push && (!pend || pop)) begin
            pend <= 1'b1;
            addr <= push_addr;
            data <= push_data;
        end else if (pop) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Config register bank with a single write port shared round-robin between the
// SPI decoder (via a one-entry holding buffer) and the on-chip host.
module reg_write_arbiter
    import spi_regs_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reg_write_arbiter_if.slave      bus,
    input  logic                    err_clr,
    output logic [DATA_W-1:0]       en_reg_out_7_0,
    output logic [DATA_W-1:0]       en_reg_out_15_8,
    output logic [DATA_W-1:0]       en_reg_pwm_7_0,
    output logic [DATA_W-1:0]       en_reg_pwm_15_8,
    output logic [DATA_W-1:0]       pwm_duty_cycle,
    output logic                    wr_commit,
    output logic                    wr_src,
    output logic [7:0]              wr_count,
    output logic                    addr_err,
    output logic                    spi_ovf
);

    logic              pend;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              ovf_set;
    logic              req_s;
    logic              req_h;
    logic              grant_s;
    logic              grant_h;
    logic              any_grant;
    logic              addr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    wr_src_e           last_grant;

    spi_wr_holdbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_holdbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.spi_wr_valid),
        .push_addr (bus.spi_wr_addr),
        .push_data (bus.spi_wr_data),
        .pop       (grant_s),
        .pend      (pend),
        .addr      (buf_addr),
        .data      (buf_data),
        .ovf       (ovf_set)
    );

    // Requests are qualified by rst_n so host_wr_ready stays low while reset is held.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        req_s   = pend & ~bus.host_lock & rst_n;
        req_h   = bus.host_wr_valid & rst_n;
        grant_s = 1'b0;
        grant_h = 1'b0;
        wr_addr = buf_addr;
        wr_data = buf_data;
        if (req_s && req_h) begin
            if (last_grant == SRC_HOST) grant_s = 1'b1;
            else                        grant_h = 1'b1;
        end else begin
            grant_s = req_s;
            grant_h = req_h;
        end
        if (grant_h) begin
            wr_addr = bus.host_wr_addr;
            wr_data = bus.host_wr_data;
        end
    end

    assign any_grant         = grant_s | grant_h;
    assign addr_ok           = wr_addr < ADDR_W'(NUM_REGS);
    assign bus.host_wr_ready = grant_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the config registers drive output enables, so they are reset rather than left undefined.
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            last_grant      <= SRC_HOST;
            wr_commit       <= 1'b0;
            wr_src          <= SRC_SPI;
            wr_count        <= '0;
            addr_err        <= 1'b0;
            spi_ovf         <= 1'b0;
        end else begin
            wr_commit <= any_grant;
            wr_src    <= grant_h ? SRC_HOST : SRC_SPI;
            if (any_grant) begin
                last_grant <= grant_h ? SRC_HOST : SRC_SPI;
                wr_count   <= wr_count + 8'd1;
                if (addr_ok) begin
                    case (wr_addr)
                        REG_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
                        REG_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
                        REG_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
                        REG_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
                        REG_PWM_DUTY:  pwm_duty_cycle  <= wr_data;
                        default: ;
                    endcase
                end
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            addr_err <= (any_grant & ~addr_ok) | (addr_err & ~err_clr);
            spi_ovf  <= ovf_set | (spi_ovf & ~err_clr);
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the register bank.
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_commit, wr_src, addr_err, spi_ovf;
    logic [7:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    reg_write_arbiter_if bus ();

    reg_write_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .err_clr         (err_clr),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_commit       (wr_commit),
        .wr_src          (wr_src),
        .wr_count        (wr_count),
        .addr_err        (addr_err),
        .spi_ovf         (spi_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: pending SPI writes as a queue (capacity one), registers as an array.
    typedef struct {
        bit [6:0] addr;
        bit [7:0] data;
    } wr_t;

    wr_t      spi_q[$];
    bit [7:0] m_regs[5];
    bit [7:0] m_count;
    bit       m_commit, m_src, m_addr_err, m_ovf;
    bit       m_last_host;
    bit       host_taken;
    logic     last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        spi_q.delete();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_count     = 8'h00;
        m_commit    = 1'b0;
        m_src       = 1'b0;
        m_addr_err  = 1'b0;
        m_ovf       = 1'b0;
        m_last_host = 1'b1;
    endtask

    // The host loses only when SPI also competes and the previous winner was the host.
    function automatic bit model_host_grant();
        bit spi_competes = (spi_q.size() != 0) && !bus.host_lock;
        return bus.host_wr_valid && !(spi_competes && m_last_host);
    endfunction

    task automatic model_edge();
        bit  spi_competes = (spi_q.size() != 0) && !bus.host_lock;
        bit  gh = model_host_grant();
        bit  gs = spi_competes && !gh;
        bit  err = 1'b0;
        bit  ovf = 1'b0;
        wr_t w;
        w.addr = 7'h00;
        w.data = 8'h00;
        if (gh) begin
            w.addr = bus.host_wr_addr;
            w.data = bus.host_wr_data;
        end else if (gs) begin
            w = spi_q.pop_front();
        end
        m_commit = gh || gs;
        m_src    = gh;
        if (m_commit) begin
            m_last_host = gh;
            m_count     = m_count + 8'd1;
            if (w.addr < 7'd5) m_regs[w.addr] = w.data;
            else               err = 1'b1;
        end
        if (bus.spi_wr_valid) begin
            if (spi_q.size() != 0) ovf = 1'b1;
            else                   spi_q.push_back('{bus.spi_wr_addr, bus.spi_wr_data});
        end
        m_addr_err = err || (m_addr_err && !err_clr);
        m_ovf      = ovf || (m_ovf && !err_clr);
        host_taken = gh;
    endtask

    task automatic check_outputs();
        check("en_out_lo", en_reg_out_7_0, m_regs[0]);
        check("en_out_hi", en_reg_out_15_8, m_regs[1]);
        check("en_pwm_lo", en_reg_pwm_7_0, m_regs[2]);
        check("en_pwm_hi", en_reg_pwm_15_8, m_regs[3]);
        check("pwm_duty", pwm_duty_cycle, m_regs[4]);
        check("wr_commit", wr_commit, m_commit);
        if (m_commit) check("wr_src", wr_src, m_src);
        check("wr_count", wr_count, m_count);
        check("addr_err", addr_err, m_addr_err);
        check("spi_ovf", spi_ovf, m_ovf);
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        #1;
        last_ready = bus.host_wr_ready;
        check("host_wr_ready", last_ready, model_host_grant());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input bit sv, input bit [6:0] sa, input bit [7:0] sd,
                         input bit hv, input bit [6:0] ha, input bit [7:0] hd,
                         input bit lk, input bit clr);
        bus.spi_wr_valid  = sv;
        bus.spi_wr_addr   = sa;
        bus.spi_wr_data   = sd;
        bus.host_wr_valid = hv;
        bus.host_wr_addr  = ha;
        bus.host_wr_data  = hd;
        bus.host_lock     = lk;
        err_clr           = clr;
        step();
    endtask

    task automatic idle(input int n, input bit lk);
        for (int i = 0; i < n; i++) drive(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, lk, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] c0;
        bit       hb;
        bit       lk;
        bit [6:0] ha;
        bit [7:0] hd;

        bus.spi_wr_valid  = 1'b0;
        bus.spi_wr_addr   = '0;
        bus.spi_wr_data   = '0;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_addr  = '0;
        bus.host_wr_data  = '0;
        bus.host_lock     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", bus.host_wr_ready, 1'b0);
        check_outputs();
        rst_n = 1'b1;
        idle(2, 0);

        // 1: SPI write to duty cycle, visible two cycles after the pulse.
        drive(1, 7'h04, 8'h80, 0, 7'h00, 8'h00, 0, 0);
        idle(1, 0);
        check("t1_duty", pwm_duty_cycle, 8'h80);
        check("t1_src", wr_src, 1'b0);

        // 2a: last grant = host, SPI pending and host valid together -> SPI first.
        drive(0, 7'h00, 8'h00, 1, 7'h03, 8'h11, 0, 0);
        drive(1, 7'h02, 8'h33, 0, 7'h00, 8'h00, 0, 0);
        c0 = wr_count;
        drive(0, 7'h00, 8'h00, 1, 7'h01, 8'hAA, 0, 0);
        check("t2a_ready_first", last_ready, 1'b0);
        drive(0, 7'h00, 8'h00, 1, 7'h01, 8'hAA, 0, 0);
        check("t2a_ready_second", last_ready, 1'b1);
        check("t2a_count", wr_count, c0 + 8'd2);
        check("t2a_out_hi", en_reg_out_15_8, 8'hAA);
        check("t2a_pwm_lo", en_reg_pwm_7_0, 8'h33);

        // 2b: last grant = SPI -> host first. Second pulse lands in the drain cycle.
        drive(1, 7'h03, 8'h44, 0, 7'h00, 8'h00, 0, 0);
        drive(1, 7'h02, 8'h55, 0, 7'h00, 8'h00, 0, 0);
        c0 = wr_count;
        drive(0, 7'h00, 8'h00, 1, 7'h01, 8'hBB, 0, 0);
        check("t2b_ready_first", last_ready, 1'b1);
        idle(1, 0);
        check("t2b_count", wr_count, c0 + 8'd2);
        check("t2b_pwm_lo", en_reg_pwm_7_0, 8'h55);
        check("t2b_out_hi", en_reg_out_15_8, 8'hBB);

        // 3: lock starves SPI; second pulse 16 cycles later overflows.
        drive(1, 7'h00, 8'h5A, 0, 7'h00, 8'h00, 1, 0);
        idle(15, 1);
        drive(1, 7'h01, 8'h66, 0, 7'h00, 8'h00, 1, 0);
        check("t3_ovf_set", spi_ovf, 1'b1);
        idle(1, 0);
        check("t3_out_lo", en_reg_out_7_0, 8'h5A);
        check("t3_out_hi", en_reg_out_15_8, 8'hBB);
        drive(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 1);
        check("t3_ovf_clr", spi_ovf, 1'b0);

        // 4: host write to unimplemented address.
        drive(0, 7'h00, 8'h00, 1, 7'h05, 8'hFF, 0, 0);
        check("t4_ready", last_ready, 1'b1);
        check("t4_addr_err", addr_err, 1'b1);
        check("t4_commit", wr_commit, 1'b1);
        check("t4_src", wr_src, 1'b1);
        drive(0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 1);

        // 5: pulse in the drain cycle, both writes commit in order.
        drive(1, 7'h04, 8'h10, 0, 7'h00, 8'h00, 0, 0);
        drive(1, 7'h04, 8'h20, 0, 7'h00, 8'h00, 0, 0);
        check("t5_first", pwm_duty_cycle, 8'h10);
        idle(1, 0);
        check("t5_second", pwm_duty_cycle, 8'h20);
        check("t5_no_ovf", spi_ovf, 1'b0);

        // 6: reset with SPI pending and host valid.
        drive(1, 7'h00, 8'h77, 0, 7'h00, 8'h00, 1, 0);
        bus.spi_wr_valid  = 1'b0;
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = 7'h02;
        bus.host_wr_data  = 8'h99;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_ready_in_reset", bus.host_wr_ready, 1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        check("t6_duty_in_reset", pwm_duty_cycle, 8'h00);
        @(negedge clk);
        bus.host_wr_valid = 1'b0;
        bus.host_lock     = 1'b0;
        rst_n = 1'b1;
        idle(3, 0);
        check("t6_out_lo", en_reg_out_7_0, 8'h00);
        check("t6_count", wr_count, 8'h00);

        // Random traffic; the host keeps its request stable until it is accepted.
        hb = 1'b0;
        lk = 1'b0;
        ha = 7'h00;
        hd = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            if (!hb && $urandom_range(2) == 0) begin
                hb = 1'b1;
                ha = 7'($urandom_range(6));
                hd = 8'($urandom);
            end
            if ($urandom_range(15) == 0) lk = !lk;
            drive($urandom_range(3) == 0, 7'($urandom_range(6)), 8'($urandom),
                  hb, ha, hd, lk, $urandom_range(19) == 0);
            if (host_taken) hb = 1'b0;
        end
        idle(2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
